// File: rtl/frame_gen_pkg.sv
// Shared types, constants and the colour-bar reference shared by the frame generator and checker.
package frame_gen_pkg;

  localparam int NUMPIXELPLANES_DEF = 3;
  localparam int PLANE_W            = 2;

  localparam logic [15:0] GEN_CORE_ID = 16'h0DEB;
  localparam logic [15:0] CHK_CORE_ID = 16'h0DEC;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_CLEAR       = 1;
  localparam int CTRL_HALT_ON_ERR = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Bars are quarter-width red, green and blue, then white for the remainder.
  function automatic logic [7:0] expected_pixel(input logic [12:0]         col,
                                                input logic [15:0]         width,
                                                input logic [PLANE_W-1:0]  plane);
    logic [16:0] q;
    logic [16:0] h;
    logic [16:0] hq;
    logic [16:0] c;
    logic [7:0]  px;
    q  = {3'b000, width[15:2]};
    h  = {2'b00, width[15:1]};
    hq = q + h;
    c  = {4'b0000, col};
    if (c < q) begin
      px = (plane == 2'd0) ? 8'hFF : 8'h00;
    end else if (c < h) begin
      px = (plane == 2'd1) ? 8'hFF : 8'h00;
    end else if (c < hq) begin
      px = (plane == 2'd2) ? 8'hFF : 8'h00;
    end else begin
      px = 8'hFF;
    end
    return px;
  endfunction

endpackage

// File: rtl/frame_position_counter.sv
// Plane/column/row position tracker with wrap and an end-of-frame pulse.
module frame_position_counter
  import frame_gen_pkg::*;
#(
  parameter int NUM_PLANES = NUMPIXELPLANES_DEF
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               advance,
  input  logic [12:0]        width,
  input  logic [12:0]        height,
  output logic [PLANE_W-1:0] plane,
  output logic [12:0]        col,
  output logic [12:0]        row,
  output logic               frame_done
);

  logic plane_wrap_s;
  logic col_wrap_s;
  logic row_wrap_s;

  // Greater-or-equal keeps the counters bounded if the geometry shrinks mid-frame.
  assign plane_wrap_s = (plane >= PLANE_W'(NUM_PLANES - 1));
  assign col_wrap_s   = (({1'b0, col} + 14'd1) >= {1'b0, width});
  assign row_wrap_s   = (({1'b0, row} + 14'd1) >= {1'b0, height});
  assign frame_done   = advance && plane_wrap_s && col_wrap_s && row_wrap_s;

  // Position registers
  always_ff @(posedge clk) begin
    if (clear) begin
      plane <= '0;
      col   <= 13'd0;
      row   <= 13'd0;
    end else if (advance) begin
      if (plane_wrap_s) begin
        plane <= '0;
        if (col_wrap_s) begin
          col <= 13'd0;
          row <= row_wrap_s ? 13'd0 : row + 13'd1;
        end else begin
          col <= col + 13'd1;
        end
      end else begin
        plane <= plane + PLANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_checker_core.sv
// Stream-sink checker for the colour-bar generator: data, last-flag and frame accounting.
// Optional producer backpressure LFSR is built when FRAME_CHECKER_BACKPRESSURE_EN is defined.
module frame_checker_core
  import frame_gen_pkg::*;
#(
  parameter int NUMPIXELPLANES = NUMPIXELPLANES_DEF,
  parameter int ERR_CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           dataIn,
  input  logic                 dataInValid,
  input  logic                 dataInLast,
  output logic                 dataInReady,
  input  logic [31:0]          controlRegister,
  input  logic [31:0]          heightWidthRegister,
  input  logic [31:0]          dataInLastPeriod,
  output logic [31:0]          rowColCounter,
  output logic [ERR_CNT_W-1:0] pixelErrorCount,
  output logic [ERR_CNT_W-1:0] lastErrorCount,
  output logic [ERR_CNT_W-1:0] frameCount,
  output logic [31:0]          firstErrorRowCol,
  output logic [31:0]          statusRegister,
  output logic [15:0]          CoreID
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_ZERO = {ERR_CNT_W{1'b0}};

  state_t               state_r, state_next_s;
  logic                 clear_s, enable_s, halt_on_err_s, cfg_err_s, stall_s;
  logic                 ready_s, beat_s, frame_done_s;
  logic [PLANE_W-1:0]   plane_s;
  logic [12:0]          col_s, row_s;
  logic [24:0]          period_s, last_idx_r;
  logic                 last_exp_s, pix_mis_s, last_mis_s;
  logic                 pix_err_r, last_err_r, resync_r;
  logic [ERR_CNT_W-1:0] pix_cnt_r, last_cnt_r, frame_cnt_r;
  logic [31:0]          first_err_r, status_r;
  logic                 unused_s;

  assign clear_s       = reset || controlRegister[CTRL_CLEAR];
  assign enable_s      = controlRegister[CTRL_ENABLE];
  assign halt_on_err_s = controlRegister[CTRL_HALT_ON_ERR];
  assign cfg_err_s     = (heightWidthRegister[12:0] == 13'd0) || (heightWidthRegister[28:16] == 13'd0);
  assign period_s      = dataInLastPeriod[24:0];
  assign unused_s      = ^{controlRegister[31:3], heightWidthRegister[31:29], dataInLastPeriod[31:25]};

`ifdef FRAME_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_r;
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 driving random stalls
  always_ff @(posedge clk) begin
    if (clear_s) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end
  assign stall_s = (lfsr_r[1:0] == 2'b00);
`else
  assign stall_s = 1'b0;
`endif

  // Ready follows RUN; a bad geometry blocks acceptance immediately
  always_comb begin
    ready_s = 1'b0;
    if ((state_r == RUN) && !cfg_err_s) begin
      ready_s = !stall_s;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign beat_s     = dataInValid && ready_s;
  assign pix_mis_s  = beat_s && (dataIn != expected_pixel(col_s, heightWidthRegister[15:0], plane_s));
  assign last_exp_s = (last_idx_r == period_s);
  assign last_mis_s = beat_s && (dataInLast != last_exp_s);

  frame_position_counter #(
    .NUM_PLANES (NUMPIXELPLANES)
  ) u_pos (
    .clk        (clk),
    .clear      (clear_s),
    .advance    (beat_s),
    .width      (heightWidthRegister[12:0]),
    .height     (heightWidthRegister[28:16]),
    .plane      (plane_s),
    .col        (col_s),
    .row        (row_s),
    .frame_done (frame_done_s)
  );

  // Next-state logic; halting reacts on the offending beat itself
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable_s && !cfg_err_s) state_next_s = RUN;
        else                        state_next_s = IDLE;
      end
      RUN: begin
        if (cfg_err_s || !enable_s)                       state_next_s = IDLE;
        else if (halt_on_err_s && (pix_mis_s || last_mis_s)) state_next_s = HALT;
        else                                              state_next_s = RUN;
      end
      HALT: begin
        if (cfg_err_s) state_next_s = IDLE;
        else           state_next_s = HALT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, error flags, last-flag index and saturating counters
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r     <= IDLE;
      pix_err_r   <= 1'b0;
      last_err_r  <= 1'b0;
      resync_r    <= 1'b0;
      last_idx_r  <= 25'd0;
      pix_cnt_r   <= CNT_ZERO;
      last_cnt_r  <= CNT_ZERO;
      frame_cnt_r <= CNT_ZERO;
      first_err_r <= 32'd0;
      status_r    <= 32'd0;
    end else begin
      state_r    <= state_next_s;
      pix_err_r  <= pix_mis_s;
      last_err_r <= last_mis_s;
      resync_r   <= last_mis_s && dataInLast;
      // An unexpected flag realigns the packet index one cycle after its beat
      if (resync_r) begin
        last_idx_r <= 25'd0;
      end else if (beat_s) begin
        last_idx_r <= (last_idx_r >= period_s) ? 25'd0 : last_idx_r + 25'd1;
      end
      if (pix_err_r && (pix_cnt_r != CNT_MAX))     pix_cnt_r   <= pix_cnt_r + CNT_ONE;
      if (last_err_r && (last_cnt_r != CNT_MAX))   last_cnt_r  <= last_cnt_r + CNT_ONE;
      if (frame_done_s && (frame_cnt_r != CNT_MAX)) frame_cnt_r <= frame_cnt_r + CNT_ONE;
      if (pix_mis_s && !pix_err_r && (pix_cnt_r == CNT_ZERO)) begin
        first_err_r <= {3'b000, row_s, 3'b000, col_s};
      end
      status_r <= {28'd0,
                   (pix_cnt_r != CNT_ZERO) || (last_cnt_r != CNT_ZERO),
                   cfg_err_s,
                   state_r == HALT,
                   state_r == RUN};
    end
  end

  assign dataInReady      = ready_s;
  assign rowColCounter    = {3'b000, row_s, 3'b000, col_s};
  assign pixelErrorCount  = pix_cnt_r;
  assign lastErrorCount   = last_cnt_r;
  assign frameCount       = frame_cnt_r;
  assign firstErrorRowCol = first_err_r;
  assign statusRegister   = status_r;
  assign CoreID           = CHK_CORE_ID;

endmodule
